// File: rtl/ide_device.sv
// ATA device model: task-file registers, PIO READ/WRITE SECTOR(S) through a
// 256-word sector buffer backed by a word-wide memory port.
module ide_device #(
  parameter int LBA_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            ide_cs,
  input  logic [2:0]            ide_da,
  input  logic                  ide_dior,
  input  logic                  ide_diow,
  input  logic [15:0]           ide_data_in,
  output logic [15:0]           ide_data_out,
  output logic                  ide_data_oe,
  output logic                  ide_intrq,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    RD_XFER = 3'd2,
    WR_XFER = 3'd3,
    FLUSH   = 3'd4,
    SRST    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        dior_q, diow_q;
  logic [7:0]  features, error, seccnt, ptr;
  logic [27:0] lba;
  logic        dev6, nien, srst, err;
  logic [8:0]  cnt;
  logic [15:0] sbuf [256];

  logic        unused_features;
  assign unused_features = ^features;

  logic        wr_edge, rd_edge, cmd_blk, ctl_blk, bsy, drq;
  logic        tf_wr, cmd_wr, ctl_wr, data_wr, data_rd, stat_rd;
  logic        srst_set, srst_done, mem_done, last_word, cnt_last;
  logic        is_read_cmd, is_write_cmd, cmd_bad;
  logic        fetch_go, flush_go, fetch_done, next_sector;
  logic        rd_sector_end, wr_sector_end, set_irq;
  logic [27:0] lba_inc, fetch_lba;
  logic [8:0]  cnt_load;
  logic [7:0]  status;
  logic [15:0] rd_val;

  // Strobe edges use the previous registered sample of each strobe.
  assign wr_edge  = !diow_q && ide_diow;
  assign rd_edge  = !dior_q && ide_dior;
  assign cmd_blk  = (ide_cs == 2'b10);
  assign ctl_blk  = (ide_cs == 2'b01) && (ide_da == 3'd6);
  assign bsy      = (state_q == FETCH) || (state_q == FLUSH) || (state_q == SRST);
  assign drq      = (state_q == RD_XFER) || (state_q == WR_XFER);
  assign status   = {bsy, state_q != SRST, 2'b00, drq, 2'b00, err};

  assign tf_wr    = wr_edge && cmd_blk && !bsy;
  assign cmd_wr   = tf_wr && (ide_da == 3'd7);
  assign ctl_wr   = wr_edge && ctl_blk;
  assign data_wr  = wr_edge && cmd_blk && (ide_da == 3'd0) && (state_q == WR_XFER);
  assign data_rd  = rd_edge && cmd_blk && (ide_da == 3'd0) && (state_q == RD_XFER);
  assign stat_rd  = rd_edge && cmd_blk && (ide_da == 3'd7);
  assign srst_set = ctl_wr && ide_data_in[2];

  assign is_read_cmd  = (ide_data_in[7:0] == 8'h20) || (ide_data_in[7:0] == 8'h21);
  assign is_write_cmd = (ide_data_in[7:0] == 8'h30) || (ide_data_in[7:0] == 8'h31);
  assign cmd_bad      = cmd_wr && !is_read_cmd && !is_write_cmd;

  assign mem_done  = mem_req && mem_ack && (mem_addr[7:0] == 8'hFF);
  assign last_word = (ptr == 8'hFF);
  assign cnt_last  = (cnt == 9'd1);
  assign cnt_load  = (seccnt == 8'h00) ? 9'd256 : {1'b0, seccnt};
  assign lba_inc   = lba + 28'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (srst_set) begin
      state_d = SRST;
    end else begin
      case (state_q)
        IDLE, RD_XFER, WR_XFER: begin
          if (cmd_wr) begin
            if (is_read_cmd)       state_d = FETCH;
            else if (is_write_cmd) state_d = WR_XFER;
            else                   state_d = IDLE;
          end else if ((state_q == RD_XFER) && data_rd && last_word) begin
            state_d = cnt_last ? IDLE : FETCH;
          end else if ((state_q == WR_XFER) && data_wr && last_word) begin
            state_d = FLUSH;
          end
        end
        FETCH:   if (mem_done) state_d = RD_XFER;
        FLUSH:   if (mem_done) state_d = cnt_last ? IDLE : WR_XFER;
        SRST:    if (ctl_wr)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign fetch_go      = (state_d == FETCH) && (state_q != FETCH);
  assign flush_go      = (state_d == FLUSH) && (state_q != FLUSH);
  assign fetch_done    = (state_q == FETCH) && (state_d == RD_XFER);
  assign srst_done     = (state_q == SRST) && (state_d == IDLE);
  assign next_sector   = ((state_q == RD_XFER) && (state_d == FETCH)) ||
                         ((state_q == FLUSH) && (state_d == WR_XFER));
  assign rd_sector_end = (state_q == RD_XFER) && data_rd && last_word && !srst_set;
  assign wr_sector_end = (state_q == FLUSH) && mem_done && !srst_set;
  assign set_irq       = cmd_bad || fetch_done || wr_sector_end;
  // A follow-on read sector is fetched from the incremented LBA.
  assign fetch_lba     = next_sector ? lba_inc : lba;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dior_q    <= 1'b1;
      diow_q    <= 1'b1;
      features  <= '0;
      error     <= 8'h01;
      seccnt    <= 8'h01;
      lba       <= '0;
      dev6      <= 1'b0;
      nien      <= 1'b0;
      srst      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      ide_intrq <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      dior_q <= ide_dior;
      diow_q <= ide_diow;

      if (tf_wr) begin
        case (ide_da)
          3'd1: features   <= ide_data_in[7:0];
          3'd2: seccnt     <= ide_data_in[7:0];
          3'd3: lba[7:0]   <= ide_data_in[7:0];
          3'd4: lba[15:8]  <= ide_data_in[7:0];
          3'd5: lba[23:16] <= ide_data_in[7:0];
          3'd6: begin
            lba[27:24] <= ide_data_in[3:0];
            dev6       <= ide_data_in[6];
          end
          default: ;
        endcase
      end
      if (ctl_wr) begin
        nien <= ide_data_in[1];
        srst <= ide_data_in[2];
      end

      if (cmd_wr) begin
        err   <= cmd_bad;
        error <= cmd_bad ? 8'h04 : 8'h00;
        cnt   <= cnt_load;
        ptr   <= '0;
      end
      if (srst_set) begin
        err <= 1'b0;
      end else if (srst_done) begin
        err   <= 1'b0;
        error <= 8'h01;
      end

      if (data_rd || data_wr) ptr <= ptr + 8'd1;
      if (fetch_done) ptr <= '0;
      if (next_sector) begin
        lba <= lba_inc;
        ptr <= '0;
      end
      if (rd_sector_end || wr_sector_end) cnt <= cnt - 9'd1;

      // Memory handshake: keep streaming while the sector is incomplete,
      // otherwise (done, abort) release the request on the ack.
      if (mem_req && mem_ack) begin
        if (((state_q == FETCH) || (state_q == FLUSH)) && (state_d == state_q)) begin
          mem_addr[7:0] <= mem_addr[7:0] + 8'd1;
          mem_wdata     <= sbuf[mem_addr[7:0] + 8'd1];
        end else begin
          mem_req <= 1'b0;
        end
      end
      if (fetch_go) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {fetch_lba[LBA_BITS-1:0], 8'h00};
      end
      if (flush_go) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {lba[LBA_BITS-1:0], 8'h00};
        mem_wdata <= sbuf[0];
      end

      if (srst_set) begin
        ide_intrq <= 1'b0;
      end else begin
        if (cmd_wr || stat_rd) ide_intrq <= 1'b0;
        if (set_irq && !nien)  ide_intrq <= 1'b1;
      end
    end
  end

  // Sector buffer holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    if ((state_q == FETCH) && mem_req && mem_ack && !mem_we)
      sbuf[mem_addr[7:0]] <= mem_rdata;
    else if (data_wr)
      sbuf[ptr] <= ide_data_in;
  end

  always_comb begin
    rd_val = '0;
    if (cmd_blk) begin
      case (ide_da)
        3'd0:    rd_val = (state_q == RD_XFER) ? sbuf[ptr] : 16'h0000;
        3'd1:    rd_val = {8'h00, error};
        3'd2:    rd_val = {8'h00, seccnt};
        3'd3:    rd_val = {8'h00, lba[7:0]};
        3'd4:    rd_val = {8'h00, lba[15:8]};
        3'd5:    rd_val = {8'h00, lba[23:16]};
        3'd6:    rd_val = {9'h000, dev6, 2'b00, lba[27:24]};
        default: rd_val = {8'h00, status};
      endcase
    end else if (ctl_blk) begin
      rd_val = {8'h00, status};
    end
  end

  assign ide_data_oe  = !ide_dior && (cmd_blk || ctl_blk);
  assign ide_data_out = ide_data_oe ? rd_val : 16'h0000;

endmodule
